saw_seq_ctrl: RTL and testbench

Note sequencer that drives the sawtooth generator's `i_targetf` and `i_pause` inputs from a small programmable note table. Each entry holds a target frequency and a duration in 48 kHz ticks. Notes play in order, separated by a fixed silent gap, with optional looping. The block sits between the host/config logic and the generator, and takes the generator's `o_pulse` 48 kHz strobe as its time base.

---
 rtl/saw_seq_ctrl_if.sv | 35 +++
 rtl/saw_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_saw_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/saw_seq_ctrl_if.sv
// Host/generator-side signal bundle for the note sequencer.
// The master modport is the host driving the table and playback controls.
interface saw_seq_ctrl_if #(
  parameter int DEPTH = 16,
  parameter int DUR_W = 16
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             i_tick;
  logic             i_wr_en;
  logic [AW-1:0]    i_wr_addr;
  logic [23:0]      i_wr_freq;
  logic [DUR_W-1:0] i_wr_dur;
  logic             i_start;
  logic             i_stop;
  logic             i_loop;

  logic [23:0]      o_targetf;
  logic             o_pause;
  logic             o_busy;
  logic [AW-1:0]    o_idx;
  logic             o_done;

  modport master (
    output i_tick, i_wr_en, i_wr_addr, i_wr_freq, i_wr_dur,
           i_start, i_stop, i_loop,
    input  o_targetf, o_pause, o_busy, o_idx, o_done
  );

  modport slave (
    input  i_tick, i_wr_en, i_wr_addr, i_wr_freq, i_wr_dur,
           i_start, i_stop, i_loop,
    output o_targetf, o_pause, o_busy, o_idx, o_done
  );
endinterface

// File: rtl/saw_seq_ctrl.sv
// Note sequencer: plays a programmable table of (frequency, duration) notes
// into the sawtooth generator, timed by the generator's 48 kHz strobe.
module saw_seq_ctrl #(
  parameter int DEPTH     = 16,
  parameter int DUR_W     = 16,
  parameter int GAP_TICKS = 480
) (
  input  logic          i_clk48,
  input  logic          i_rst48,
  saw_seq_ctrl_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [GW-1:0] GAP_INIT = GW'(GAP_TICKS);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t           state, state_n;
  logic [23:0]      freq_mem [DEPTH];
  logic [DUR_W-1:0] dur_mem  [DEPTH];
  logic [AW-1:0]    idx, idx_n;
  logic [23:0]      targetf, targetf_n;
  logic [DUR_W-1:0] remain, remain_n;
  logic [GW-1:0]    gap, gap_n;
  logic             pause, pause_n;
  logic             done, done_n;

  logic [AW-1:0]    nxt, adv_idx;
  logic             end_seq, adv_stop, do_adv;

  // Where the sequence goes after the current note (and its gap) completes.
  always_comb begin
    nxt      = idx + 1'b1;
    end_seq  = (idx == LAST_IDX) || (dur_mem[nxt] == '0);
    adv_idx  = nxt;
    adv_stop = 1'b0;
    if (end_seq) begin
      adv_idx  = '0;
      adv_stop = !bus.i_loop || (dur_mem[0] == '0);
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    targetf_n = targetf;
    remain_n  = remain;
    gap_n     = gap;
    done_n    = 1'b0;
    do_adv    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.i_start) begin
          idx_n = '0;
          if (dur_mem[0] != '0) begin
            state_n   = PLAY;
            targetf_n = freq_mem[0];
            remain_n  = dur_mem[0];
          end else begin
            done_n = 1'b1;
          end
        end
      end
      PLAY: begin
        if (bus.i_tick) begin
          if (remain > DUR_W'(1)) begin
            remain_n = remain - 1'b1;
          end else if (GAP_TICKS > 0) begin
            state_n = GAP;
            gap_n   = GAP_INIT;
          end else begin
            do_adv = 1'b1;
          end
        end
      end
      GAP: begin
        if (bus.i_tick) begin
          if (gap > GW'(1)) gap_n = gap - 1'b1;
          else              do_adv = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (do_adv) begin
      if (adv_stop) begin
        state_n   = IDLE;
        targetf_n = '0;
        done_n    = 1'b1;
      end else begin
        state_n   = PLAY;
        idx_n     = adv_idx;
        targetf_n = freq_mem[adv_idx];
        remain_n  = dur_mem[adv_idx];
      end
    end

    // Stop overrides everything decided above, including a same-cycle tick.
    if (bus.i_stop) begin
      state_n   = IDLE;
      targetf_n = '0;
      done_n    = 1'b0;
    end

    pause_n = (state_n != PLAY);
  end

  always_ff @(posedge i_clk48) begin
    if (i_rst48) begin
      state   <= IDLE;
      idx     <= '0;
      targetf <= '0;
      remain  <= '0;
      gap     <= '0;
      pause   <= 1'b1;
      done    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        freq_mem[i] <= '0;
        dur_mem[i]  <= '0;
      end
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      targetf <= targetf_n;
      remain  <= remain_n;
      gap     <= gap_n;
      pause   <= pause_n;
      done    <= done_n;
      // Loads above read the pre-write contents when addresses collide.
      if (bus.i_wr_en) begin
        freq_mem[bus.i_wr_addr] <= bus.i_wr_freq;
        dur_mem[bus.i_wr_addr]  <= bus.i_wr_dur;
      end
    end
  end

  assign bus.o_targetf = targetf;
  assign bus.o_pause   = pause;
  assign bus.o_busy    = (state != IDLE);
  assign bus.o_idx     = idx;
  assign bus.o_done    = done;
endmodule

// File: tb/tb_saw_seq_ctrl.sv
// Scoreboard bench for saw_seq_ctrl: expected output changes are queued with the
// tick count at which they must appear; monitors pop on every observed change.
module tb_saw_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  saw_seq_ctrl_if #(.DEPTH(16), .DUR_W(16)) bus_a ();
  saw_seq_ctrl_if #(.DEPTH(2),  .DUR_W(16)) bus_b ();

  saw_seq_ctrl #(.DEPTH(16), .DUR_W(16), .GAP_TICKS(2)) dut_a (
    .i_clk48 (clk),
    .i_rst48 (rst),
    .bus     (bus_a.slave)
  );

  saw_seq_ctrl #(.DEPTH(2), .DUR_W(16), .GAP_TICKS(0)) dut_b (
    .i_clk48 (clk),
    .i_rst48 (rst),
    .bus     (bus_b.slave)
  );

  typedef struct packed {
    logic [23:0] f;
    logic        p;
    logic        b;
    logic [3:0]  idx;
    logic        d;
  } obs_t;

  typedef struct {
    int   stamp;
    obs_t o;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   cnt_a = 0;
  int   cnt_b = 0;
  int   tests = 0;
  int   fails = 0;
  obs_t prev_a = 'x;
  obs_t prev_b = 'x;
  obs_t cur_a, cur_b;
  exp_t e_a, e_b;

  function automatic exp_t mk(int st, int f, bit p, bit bz, int idx, bit d);
    exp_t e;
    e.stamp = st;
    e.o.f   = 24'(f);
    e.o.p   = p;
    e.o.b   = bz;
    e.o.idx = 4'(idx);
    e.o.d   = d;
    return e;
  endfunction

  function automatic void ea(int st, int f, bit p, bit bz, int idx, bit d);
    q_a.push_back(mk(st, f, p, bz, idx, d));
  endfunction

  function automatic void eb(int st, int f, bit p, bit bz, int idx, bit d);
    q_b.push_back(mk(st, f, p, bz, idx, d));
  endfunction

  task automatic cyc_a(input bit tk, input bit st, input bit sp, input bit lp,
                       input bit we = 1'b0, input int addr = 0, input int f = 0,
                       input int d = 0, input bit r = 1'b0);
    @(posedge clk);
    #2;
    rst             = r;
    bus_a.i_tick    = tk;
    bus_a.i_start   = st;
    bus_a.i_stop    = sp;
    bus_a.i_loop    = lp;
    bus_a.i_wr_en   = we;
    bus_a.i_wr_addr = 4'(addr);
    bus_a.i_wr_freq = 24'(f);
    bus_a.i_wr_dur  = 16'(d);
    if (tk) cnt_a++;
  endtask

  task automatic cyc_b(input bit tk, input bit st, input bit sp, input bit lp,
                       input bit we = 1'b0, input int addr = 0, input int f = 0,
                       input int d = 0);
    @(posedge clk);
    #2;
    rst             = 1'b0;
    bus_b.i_tick    = tk;
    bus_b.i_start   = st;
    bus_b.i_stop    = sp;
    bus_b.i_loop    = lp;
    bus_b.i_wr_en   = we;
    bus_b.i_wr_addr = 1'(addr);
    bus_b.i_wr_freq = 24'(f);
    bus_b.i_wr_dur  = 16'(d);
    if (tk) cnt_b++;
  endtask

  always @(posedge clk) begin
    #1;
    cur_a.f   = bus_a.o_targetf;
    cur_a.p   = bus_a.o_pause;
    cur_a.b   = bus_a.o_busy;
    cur_a.idx = 4'(bus_a.o_idx);
    cur_a.d   = bus_a.o_done;
    if (cur_a !== prev_a) begin
      prev_a = cur_a;
      tests++;
      if (q_a.size() == 0) begin
        fails++;
        $display("FAIL a_unexpected: got f=%0d pause=%0b busy=%0b idx=%0d done=%0b @tick %0d, required no change",
                 cur_a.f, cur_a.p, cur_a.b, cur_a.idx, cur_a.d, cnt_a);
      end else begin
        e_a = q_a.pop_front();
        if (e_a.stamp != cnt_a || e_a.o !== cur_a)
          begin
            fails++;
            $display("FAIL a_event: got f=%0d pause=%0b busy=%0b idx=%0d done=%0b @tick %0d, required f=%0d pause=%0b busy=%0b idx=%0d done=%0b @tick %0d",
                     cur_a.f, cur_a.p, cur_a.b, cur_a.idx, cur_a.d, cnt_a,
                     e_a.o.f, e_a.o.p, e_a.o.b, e_a.o.idx, e_a.o.d, e_a.stamp);
          end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    cur_b.f   = bus_b.o_targetf;
    cur_b.p   = bus_b.o_pause;
    cur_b.b   = bus_b.o_busy;
    cur_b.idx = 4'(bus_b.o_idx);
    cur_b.d   = bus_b.o_done;
    if (cur_b !== prev_b) begin
      prev_b = cur_b;
      tests++;
      if (q_b.size() == 0) begin
        fails++;
        $display("FAIL b_unexpected: got f=%0d pause=%0b busy=%0b idx=%0d done=%0b @tick %0d, required no change",
                 cur_b.f, cur_b.p, cur_b.b, cur_b.idx, cur_b.d, cnt_b);
      end else begin
        e_b = q_b.pop_front();
        if (e_b.stamp != cnt_b || e_b.o !== cur_b)
          begin
            fails++;
            $display("FAIL b_event: got f=%0d pause=%0b busy=%0b idx=%0d done=%0b @tick %0d, required f=%0d pause=%0b busy=%0b idx=%0d done=%0b @tick %0d",
                     cur_b.f, cur_b.p, cur_b.b, cur_b.idx, cur_b.d, cnt_b,
                     e_b.o.f, e_b.o.p, e_b.o.b, e_b.o.idx, e_b.o.d, e_b.stamp);
          end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.i_tick = 0; bus_a.i_start = 0; bus_a.i_stop = 0; bus_a.i_loop = 0;
    bus_a.i_wr_en = 0; bus_a.i_wr_addr = '0; bus_a.i_wr_freq = '0; bus_a.i_wr_dur = '0;
    bus_b.i_tick = 0; bus_b.i_start = 0; bus_b.i_stop = 0; bus_b.i_loop = 0;
    bus_b.i_wr_en = 0; bus_b.i_wr_addr = '0; bus_b.i_wr_freq = '0; bus_b.i_wr_dur = '0;

    // Reset values on both instances
    ea(0, 0, 1, 0, 0, 0);
    eb(0, 0, 1, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) cyc_a(0, 0, 0, 0);

    // Start on an empty table: one-cycle done, never busy, ticks in IDLE ignored
    cnt_a = 0;
    ea(1, 0, 1, 0, 0, 1);
    ea(2, 0, 1, 0, 0, 0);
    cyc_a(1, 1, 0, 0);
    repeat (4) cyc_a(1, 0, 0, 0);

    cyc_a(0, 0, 0, 0, 1, 0, 440, 3);
    cyc_a(0, 0, 0, 0, 1, 1, 880, 2);
    cyc_a(0, 0, 0, 0, 1, 2, 123, 0);
    repeat (2) cyc_a(0, 0, 0, 0);

    // One pass, no loop; the tick in the start cycle is not counted
    cnt_a = 0;
    ea(1,  440, 0, 1, 0, 0);
    ea(4,  440, 1, 1, 0, 0);
    ea(6,  880, 0, 1, 1, 0);
    ea(8,  880, 1, 1, 1, 0);
    ea(10, 0,   1, 0, 1, 1);
    ea(11, 0,   1, 0, 1, 0);
    cyc_a(1, 1, 0, 0);
    repeat (12) cyc_a(1, 0, 0, 0);
    repeat (2) cyc_a(0, 0, 0, 0);

    // Looping: three wraps with no done, then stop coincident with tick 2
    cnt_a = 0;
    ea(1, 440, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      ea(1 + 9*k + 3, 440, 1, 1, 0, 0);
      ea(1 + 9*k + 5, 880, 0, 1, 1, 0);
      ea(1 + 9*k + 7, 880, 1, 1, 1, 0);
      ea(1 + 9*k + 9, 440, 0, 1, 0, 0);
    end
    ea(30, 0, 1, 0, 0, 0);
    cyc_a(1, 1, 0, 1);
    repeat (28) cyc_a(1, 0, 0, 1);
    cyc_a(1, 0, 1, 1);
    repeat (4) cyc_a(1, 0, 0, 0);

    // Writes to entry 0 at load time and during its playback
    cnt_a = 0;
    ea(1,  440,  0, 1, 0, 0);
    ea(4,  440,  1, 1, 0, 0);
    ea(6,  880,  0, 1, 1, 0);
    ea(8,  880,  1, 1, 1, 0);
    ea(10, 1000, 0, 1, 0, 0);
    ea(15, 1000, 1, 1, 0, 0);
    ea(16, 0,    1, 0, 0, 0);
    cyc_a(1, 1, 0, 1, 1, 0, 600, 7);
    cyc_a(1, 0, 0, 1, 1, 0, 1000, 5);
    repeat (13) cyc_a(1, 0, 0, 1);
    cyc_a(1, 0, 1, 1);
    repeat (3) cyc_a(1, 0, 0, 0);

    // Reset mid-note, then start finds the table cleared
    cnt_a = 0;
    ea(1, 1000, 0, 1, 0, 0);
    ea(3, 0,    1, 0, 0, 0);
    ea(4, 0,    1, 0, 0, 1);
    ea(5, 0,    1, 0, 0, 0);
    cyc_a(1, 1, 0, 0);
    cyc_a(1, 0, 0, 0);
    cyc_a(1, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    cyc_a(1, 1, 0, 0);
    repeat (3) cyc_a(1, 0, 0, 0);

    // DEPTH=2, no gap: last index ends the sequence; start while busy ignored
    cyc_b(0, 0, 0, 0, 1, 0, 100, 1);
    cyc_b(0, 0, 0, 0, 1, 1, 200, 1);
    cyc_b(0, 0, 0, 0);
    cnt_b = 0;
    eb(0, 100, 0, 1, 0, 0);
    eb(1, 200, 0, 1, 1, 0);
    eb(2, 0,   1, 0, 1, 1);
    eb(3, 0,   1, 0, 1, 0);
    cyc_b(0, 1, 0, 0);
    cyc_b(1, 1, 0, 0);
    cyc_b(1, 1, 0, 0);
    repeat (4) cyc_b(1, 0, 0, 0);

    repeat (3) cyc_b(0, 0, 0, 0);
    tests++;
    if (q_a.size() != 0) begin
      fails++;
      $display("FAIL a_pending: got %0d unobserved events, required 0", q_a.size());
    end
    tests++;
    if (q_b.size() != 0) begin
      fails++;
      $display("FAIL b_pending: got %0d unobserved events, required 0", q_b.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
